// File: rtl/att_serial_loader_pkg.sv
// Shared widths and FSM encoding for the serial attenuator loader.
package att_serial_loader_pkg;

    localparam int unsigned ATT_BITS = 7;
    localparam int unsigned ATT_WORD = 8;
    localparam int unsigned DIV_W    = 8;
    localparam int unsigned IDX_W    = 3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        LATCH,
        GAP
    } state_t;

endpackage

// File: rtl/att_serial_loader_tick_div.sv
// Phase timer: counts CLK_DIV cycles while enabled and flags the last
// cycle of each phase (and the one before it, for registered lookahead).
module att_serial_loader_tick_div
    import att_serial_loader_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
)(
    input  logic clk,
    input  logic resetn,
    input  logic en,
    output logic tick_c,
    output logic pre_tick_c
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] PRE  = DIV_W'(CLK_DIV - 2);

    logic [DIV_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!resetn || !en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

    assign tick_c     = en && (cnt == LAST);
    assign pre_tick_c = en && (CLK_DIV > 1) && (cnt == PRE);

endmodule

// File: rtl/att_serial_loader.sv
// Serial loader for the pre/post step attenuators: reloads a channel when its
// requested code differs from the last code shifted out, or on a force request.
module att_serial_loader #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned ATT_BITS = att_serial_loader_pkg::ATT_BITS
)(
    input  logic                clk,
    input  logic                resetn,
    input  logic [ATT_BITS-1:0] pre_att,
    input  logic [ATT_BITS-1:0] post_att,
    input  logic                force_req,
    output logic                att_si,
    output logic                att_sclk,
    output logic                att_le_pre,
    output logic                att_le_post,
    output logic                busy,
    output logic                done
);

    import att_serial_loader_pkg::*;

    state_t              state;
    logic [ATT_WORD-1:0] word;
    logic [IDX_W-1:0]    bit_idx;
    logic [ATT_BITS-1:0] shadow_pre;
    logic [ATT_BITS-1:0] shadow_post;
    logic                frc_pre;
    logic                frc_post;
    logic                sel_post;

    logic pend_pre_c;
    logic pend_post_c;
    logic div_en_c;
    logic tick_c;
    logic pre_tick_c;

    assign pend_pre_c  = (pre_att  != shadow_pre)  || frc_pre  || force_req;
    assign pend_post_c = (post_att != shadow_post) || frc_post || force_req;
    assign div_en_c    = state inside {SHIFT_LO, SHIFT_HI, LATCH, GAP};

    att_serial_loader_tick_div #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_div (
        .clk       (clk),
        .resetn    (resetn),
        .en        (div_en_c),
        .tick_c    (tick_c),
        .pre_tick_c(pre_tick_c)
    );

    // Sequencer; the word rotates so the bit on att_si is always word[0].
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            word        <= '0;
            bit_idx     <= '0;
            shadow_pre  <= '0;
            shadow_post <= '0;
            frc_pre     <= 1'b1;
            frc_post    <= 1'b1;
            sel_post    <= 1'b0;
            att_si      <= 1'b0;
            att_sclk    <= 1'b0;
            att_le_pre  <= 1'b0;
            att_le_post <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (force_req) begin
                frc_pre  <= 1'b1;
                frc_post <= 1'b1;
            end
            case (state)
                IDLE: begin
                    busy <= pend_pre_c || pend_post_c;
                    if (pend_pre_c) begin
                        state      <= LOAD;
                        sel_post   <= 1'b0;
                        word       <= ATT_WORD'(pre_att);
                        att_si     <= pre_att[0];
                        shadow_pre <= pre_att;
                        frc_pre    <= 1'b0;
                    end else if (pend_post_c) begin
                        state       <= LOAD;
                        sel_post    <= 1'b1;
                        word        <= ATT_WORD'(post_att);
                        att_si      <= post_att[0];
                        shadow_post <= post_att;
                        frc_post    <= 1'b0;
                    end
                end
                LOAD: begin
                    state    <= SHIFT_LO;
                    bit_idx  <= '0;
                    att_sclk <= 1'b0;
                end
                SHIFT_LO: begin
                    if (tick_c) begin
                        state    <= SHIFT_HI;
                        att_sclk <= 1'b1;
                    end
                end
                SHIFT_HI: begin
                    if (tick_c) begin
                        att_sclk <= 1'b0;
                        if (bit_idx == IDX_W'(ATT_WORD - 1)) begin
                            state       <= LATCH;
                            att_si      <= 1'b0;
                            att_le_pre  <= !sel_post;
                            att_le_post <= sel_post;
                            if (CLK_DIV == 1) begin
                                done <= 1'b1;
                            end
                        end else begin
                            state   <= SHIFT_LO;
                            word    <= {word[0], word[ATT_WORD-1:1]};
                            att_si  <= word[1];
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end
                end
                LATCH: begin
                    if (pre_tick_c) begin
                        done <= 1'b1;
                    end
                    if (tick_c) begin
                        state       <= GAP;
                        att_le_pre  <= 1'b0;
                        att_le_post <= 1'b0;
                    end
                end
                GAP: begin
                    if (tick_c) begin
                        state <= IDLE;
                        busy  <= pend_pre_c || pend_post_c;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_att_serial_loader.sv
// Bench for att_serial_loader: two instances (CLK_DIV 2 and 1) share stimulus;
// each has a load-level reference model feeding a queue and an output monitor.
module tb_att_serial_loader;

    logic       clk = 1'b0;
    logic       resetn;
    logic [6:0] pre_att;
    logic [6:0] post_att;
    logic       force_req;
    int         n_pass = 0;
    int         n_total = 0;
    bit         fin_chk = 1'b0;

    always #5 clk = ~clk;

    task automatic check(input string name, input int inst, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (instance %0d) got %0h expected %0h at %0t",
                      name, inst, act, exp, $time);
    endtask

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int D = (g == 0) ? 2 : 1;
        localparam int N = 1 + 18 * D;

        logic si, sclk, le_pre, le_post, busy, done;

        att_serial_loader #(.CLK_DIV(D), .ATT_BITS(7)) dut (
            .clk        (clk),
            .resetn     (resetn),
            .pre_att    (pre_att),
            .post_att   (post_att),
            .force_req  (force_req),
            .att_si     (si),
            .att_sclk   (sclk),
            .att_le_pre (le_pre),
            .att_le_post(le_post),
            .busy       (busy),
            .done       (done)
        );

        // Reference model: a load occupies N cycles; a new one may start from an idle cycle.
        logic [7:0] exp_q[$];
        int         left = 0;
        int         prev_left = 0;
        bit         ch = 1'b0;
        bit         rst_seen = 1'b1;
        logic [6:0] sh_pre = '0, sh_post = '0;
        bit         st_pre = 1'b1, st_post = 1'b1;
        bit         p_pre, p_post;

        always @(posedge clk) begin
            prev_left = left;
            rst_seen  = !resetn;
            if (!resetn) begin
                if (left > 2 * D) exp_q.delete(exp_q.size() - 1);
                left = 0; sh_pre = '0; sh_post = '0; st_pre = 1'b1; st_post = 1'b1;
            end else if (left > 0) begin
                left--;
                if (force_req) begin st_pre = 1'b1; st_post = 1'b1; end
            end else begin
                p_pre  = (pre_att  != sh_pre)  || st_pre  || force_req;
                p_post = (post_att != sh_post) || st_post || force_req;
                if (p_pre) begin
                    exp_q.push_back({1'b0, pre_att});
                    sh_pre = pre_att; st_pre = 1'b0; ch = 1'b0; left = N;
                    if (force_req) st_post = 1'b1;
                end else if (p_post) begin
                    exp_q.push_back({1'b1, post_att});
                    sh_post = post_att; st_post = 1'b0; ch = 1'b1; left = N;
                end
            end
        end

        // Monitor: rebuild each word from sclk rises, compare at the latch strobe.
        logic [7:0] bits = '0;
        logic [7:0] e;
        int         nbits = 0;
        bit         psclk = 1'b0, ple = 1'b0, in_load;

        always @(negedge clk) begin
            if (rst_seen) begin
                check("reset_outputs", g, {26'b0, si, sclk, le_pre, le_post, busy, done}, 32'd0);
                bits = '0; nbits = 0; psclk = 1'b0; ple = 1'b0;
            end else begin
                in_load = (left > 0);
                if (in_load) check("busy_in_load", g, busy, 1);
                else if (prev_left == 0) check("busy_idle", g, busy, 0);
                check("done_timing", g, done, in_load && left == D + 1);
                check("le_pre_timing", g, le_pre,
                      in_load && !ch && left >= D + 1 && left <= 2 * D);
                check("le_post_timing", g, le_post,
                      in_load && ch && left >= D + 1 && left <= 2 * D);
                if (sclk && !psclk) begin
                    if (nbits < 8) bits[nbits] = si;
                    nbits++;
                end
                if ((le_pre || le_post) && !ple) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_load", g, 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("shifted_word", g, bits, {1'b0, e[6:0]});
                        check("le_channel", g, le_post, e[7]);
                        check("sclk_rises", g, nbits, 8);
                    end
                    bits = '0; nbits = 0;
                end
                psclk = sclk;
                ple   = le_pre || le_post;
            end
        end

        always @(posedge fin_chk) check("queue_drained", g, exp_q.size(), 0);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int restore = 0;

    initial begin
        resetn = 1'b0; pre_att = 7'h15; post_att = 7'h2A; force_req = 1'b0;
        wait_cyc(3);
        resetn = 1'b1;
        wait_cyc(100);
        pre_att = 7'h7F;                          // single pre reload
        wait_cyc(60);
        pre_att = 7'h33; wait_cyc(19);            // post changes mid pre load
        post_att = 7'h55;
        wait_cyc(100);
        pre_att = 7'h0C; wait_cyc(10);            // force mid load, no value change
        force_req = 1'b1; wait_cyc(1); force_req = 1'b0;
        wait_cyc(160);
        pre_att = 7'h4C; wait_cyc(15);            // reset around the 4th bit
        resetn = 1'b0; wait_cyc(2); resetn = 1'b1;
        wait_cyc(120);
        pre_att = 7'h00; wait_cyc(60);            // toggle within one load
        pre_att = 7'h01; wait_cyc(3);
        pre_att = 7'h00;
        wait_cyc(100);
        for (int i = 0; i < 4000; i++) begin
            force_req = ($urandom_range(0, 99) == 0);
            resetn    = ($urandom_range(0, 999) != 0);
            if ($urandom_range(0, 29) == 0) pre_att  = 7'($urandom);
            if ($urandom_range(0, 29) == 0) post_att = 7'($urandom);
            if (restore == 0 && $urandom_range(0, 49) == 0) begin
                pre_att ^= 7'h01; restore = $urandom_range(1, 6);
            end else if (restore > 0) begin
                restore--;
                if (restore == 0) pre_att ^= 7'h01;
            end
            wait_cyc(1);
        end
        force_req = 1'b0; resetn = 1'b1;
        wait_cyc(200);
        fin_chk = 1'b1;
        wait_cyc(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/att_serial_loader.md
ATT_SERIAL_LOADER -- requirements
Module: att_serial_loader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, clk cycles per serial half-bit and per latch/gap phase; legal range 1..255.
REQ-002 SHALL have parameter ATT_BITS, default 7, attenuator code width.
REQ-003 SHALL have port clk  input  1  system clock (same domain as the pulses block); the only clock.
REQ-004 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port pre_att  input  7  requested pre-attenuator code from the pulses block.
REQ-006 SHALL have port post_att  input  7  requested post-attenuator code from the pulses block.
REQ-007 SHALL have port force  input  1  one-cycle request to reload both attenuators.
REQ-008 SHALL have port att_si  output  1  serial data, shared by both attenuators.
REQ-009 SHALL have port att_sclk  output  1  serial clock, shared; attenuator samples on rising edge.
REQ-010 SHALL have port att_le_pre  output  1  latch enable, pre-attenuator.
REQ-011 SHALL have port att_le_post  output  1  latch enable, post-attenuator.
REQ-012 SHALL have port busy  output  1  high while any load is in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse at the end of each completed load.

Function
REQ-014 SHALL keep per-channel shadow registers holding the last code loaded; a channel is pending when its input differs from its shadow, or when force is seen.
REQ-015 SHALL use FSM states IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH, GAP.
REQ-016 IDLE: if any channel is pending, go to LOAD next cycle; pre has priority over post.
REQ-017 LOAD (1 cycle): capture the selected input into the 8-bit shift word {1'b0, code}, copy it into that channel's shadow, drive att_si = bit 0, att_sclk = 0.
REQ-018 SHIFT_LO (CLK_DIV cycles): att_sclk = 0, att_si stable at the current bit.
REQ-019 SHIFT_HI (CLK_DIV cycles): att_sclk = 1; on exit, shift LSB-first to the next bit. After bit 7, go to LATCH; otherwise go to SHIFT_LO.
REQ-020 LATCH (CLK_DIV cycles): att_sclk = 0; assert only the selected channel's LE; done pulses on the last LATCH cycle.
REQ-021 GAP (CLK_DIV cycles): all strobes low, then return to IDLE.
REQ-022 SHALL hold busy high from LOAD through GAP inclusive: exactly 1+18*CLK_DIV cycles per load.
REQ-023 Input changes during a load SHALL NOT corrupt the word in flight; they are detected in IDLE via the shadow compare.
REQ-024 If both channels are pending, SHALL perform pre then post back-to-back; busy stays high across the IDLE cycle between them.
REQ-025 force during busy SHALL be latched as sticky pending flags for both channels, serviced after the current load.
REQ-026 An input that changes and returns to its shadow value before IDLE SHALL cause no load.
REQ-027 SHALL use a divide counter of width ceil(log2(256)) = 8 bits that wraps to 0 at CLK_DIV-1, and a 3-bit bit index.

Reset
REQ-028 While resetn = 0 at a clk edge, SHALL force: state IDLE, att_si 0, att_sclk 0, att_le_pre 0, att_le_post 0, busy 0, done 0, counters 0.
REQ-029 Reset SHALL set both force-pending flags, so both attenuators are loaded immediately after reset release.
REQ-030 Reset asserted mid-load SHALL abort with no LE pulse.

Structure
REQ-031 The shared package SHALL hold ATT_BITS, ATT_WORD = 8, and the FSM state encoding.
REQ-032 SHALL use one natural sub-module, tick_div, which produces the CLK_DIV phase-end strobe; all remaining logic is flat.

Verification
REQ-033 CLK_DIV=2, reset release with pre=7'h15, post=7'h2A -> pre load then post load; sampled words 0x15 and 0x2A, LSB-first, on sclk rises; one LE per channel; two done pulses; busy high for 74 cycles plus the IDLE gap cycle.
REQ-034 Idle; pre_att changes 7'h15 -> 7'h7F -> LOAD 1 cycle later; 8 sclk rises carrying 1,1,1,1,1,1,1,0; att_le_pre high 2 cycles; att_le_post stays 0.
REQ-035 post_att changes at the 5th sclk rise of a pre load -> pre word unchanged; post load starts after GAP.
REQ-036 force pulsed mid-load with no value change -> after the current load, both channels reload with their unchanged codes.
REQ-037 resetn low at the 4th bit -> outputs 0 next edge; no LE; after release, both channels reload.
REQ-038 CLK_DIV=1, pre toggles 7'h00 -> 7'h01 -> 7'h00 within one load -> exactly one further load, with final code 7'h00.
